// File: rtl/systolic_tile_controller_pkg.sv
// Shared types for the systolic tile controller.
// Holds the FSM state enum and the array pipeline latency helper.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    function automatic int calc_lat(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_tile_controller_if.sv
// Job, array and buffer signals of the systolic tile controller.
// SYSCTRL_STALL_CNT_EN adds the stall_cnt output.
interface systolic_tile_controller_if #(
    parameter int MAX_ROWS   = 512,
    parameter int MAX_TILES  = 16,
    parameter int ADDR_WIDTH = 10
) ();
    localparam int RW = $clog2(MAX_ROWS + 1);
    localparam int TW = $clog2(MAX_TILES + 1);
    localparam int IW = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

    logic                  start;
    logic [RW-1:0]         cfg_rows;
    logic [TW-1:0]         cfg_tiles;
    logic                  wt_valid;
    logic                  in_valid;
    logic                  sys_wt_en;
    logic                  sys_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  acc_en;
    logic [IW-1:0]         tile_idx;
    logic                  ready;
    logic                  busy;
    logic                  done;
`ifdef SYSCTRL_STALL_CNT_EN
    logic [31:0]           stall_cnt;
`endif

    modport master (
        output start, cfg_rows, cfg_tiles, wt_valid, in_valid,
        input  sys_wt_en, sys_en, rd_en, rd_addr, we, wr_addr,
        input  acc_en, tile_idx, ready, busy, done
`ifdef SYSCTRL_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  start, cfg_rows, cfg_tiles, wt_valid, in_valid,
        output sys_wt_en, sys_en, rd_en, rd_addr, we, wr_addr,
        output acc_en, tile_idx, ready, busy, done
`ifdef SYSCTRL_STALL_CNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/systolic_tile_controller.sv
// Sequences weight load, row streaming and drain for a systolic array.
// SYSCTRL_STALL_CNT_EN adds a saturating COMPUTE stall counter.
module systolic_tile_controller
    import systolic_pkg::*;
#(
    parameter int N_SIZE     = 32,
    parameter int MAX_ROWS   = 512,
    parameter int MAX_TILES  = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic clk,
    input  logic rst,
    systolic_tile_controller_if.slave bus
);
    localparam int LAT = calc_lat(N_SIZE);
    localparam int RW  = $clog2(MAX_ROWS + 1);
    localparam int TW  = $clog2(MAX_TILES + 1);
    localparam int IW  = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;
    localparam int CW  = $clog2(MAX_ROWS + LAT + 1);
    localparam int BW  = $clog2(N_SIZE + 1);

    state_t state_q, state_d;

    logic [RW-1:0]         rows_q;
    logic [TW-1:0]         tiles_q;
    logic [IW-1:0]         tile_q;
    logic [BW-1:0]         beat_q;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         adv_q;
    logic [ADDR_WIDTH-1:0] wr_q;
    logic                  busy_q;
    logic                  done_q;

    logic [RW-1:0] rows_clamp;
    logic [TW-1:0] tiles_clamp;
    logic          accept;
    logic          more_tiles;
    logic          sys_wt_en, sys_en, rd_en, we;

    assign rows_clamp  = (bus.cfg_rows > RW'(MAX_ROWS)) ?
                         RW'(MAX_ROWS) : bus.cfg_rows;
    assign tiles_clamp = (bus.cfg_tiles > TW'(MAX_TILES)) ?
                         TW'(MAX_TILES) : bus.cfg_tiles;
    assign accept      = (state_q == IDLE) && bus.start;
    assign more_tiles  = (TW'(tile_q) + TW'(1)) < tiles_q;

    always_comb begin
        state_d   = state_q;
        sys_wt_en = 1'b0;
        sys_en    = 1'b0;
        rd_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (rows_clamp == '0 || tiles_clamp == '0)
                        state_d = DONE;
                    else
                        state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                sys_wt_en = bus.wt_valid;
                if (bus.wt_valid && beat_q == BW'(N_SIZE - 1))
                    state_d = COMPUTE;
            end
            COMPUTE: begin
                sys_en = bus.in_valid;
                rd_en  = bus.in_valid;
                if (bus.in_valid && row_q == rows_q - RW'(1))
                    state_d = DRAIN;
            end
            DRAIN: begin
                sys_en = 1'b1;
                if (adv_q == CW'(rows_q) + CW'(LAT - 1))
                    state_d = more_tiles ? LOAD_W : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Mealy strobes must read idle while reset is being applied
        if (rst) begin
            sys_wt_en = 1'b0;
            sys_en    = 1'b0;
            rd_en     = 1'b0;
        end
    end

    assign we = sys_en && (adv_q >= CW'(LAT)) &&
                (adv_q < CW'(rows_q) + CW'(LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            tiles_q <= '0;
            tile_q  <= '0;
            beat_q  <= '0;
            row_q   <= '0;
            adv_q   <= '0;
            wr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (accept) begin
                rows_q  <= rows_clamp;
                tiles_q <= tiles_clamp;
                tile_q  <= '0;
            end
            if (state_d == LOAD_W && state_q != LOAD_W) begin
                beat_q <= '0;
                row_q  <= '0;
                adv_q  <= '0;
                wr_q   <= '0;
            end else begin
                if (sys_wt_en) beat_q <= beat_q + BW'(1);
                if (rd_en)     row_q  <= row_q + RW'(1);
                if (sys_en)    adv_q  <= adv_q + CW'(1);
                if (we)        wr_q   <= wr_q + ADDR_WIDTH'(1);
            end
            if (state_q == DRAIN && state_d == LOAD_W)
                tile_q <= tile_q + IW'(1);
        end
    end

`ifdef SYSCTRL_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || accept)
            stall_q <= '0;
        else if (state_q == COMPUTE && !bus.in_valid && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end

    assign bus.stall_cnt = stall_q;
`endif

    assign bus.sys_wt_en = sys_wt_en;
    assign bus.sys_en    = sys_en;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = ADDR_WIDTH'(row_q);
    assign bus.we        = we;
    assign bus.wr_addr   = wr_q;
    assign bus.acc_en    = we && (tile_q != '0);
    assign bus.tile_idx  = tile_q;
    assign bus.busy      = busy_q;
    assign bus.ready     = !busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Randomized bench for systolic_tile_controller (N_SIZE=4).
// Checks stall_cnt too when SYSCTRL_STALL_CNT_EN is defined.
module tb_systolic_tile_controller;
    localparam int N   = 4;
    localparam int LAT = 2 * N - 2;
    localparam int MR  = 512;
    localparam int MT  = 16;

    typedef struct {
        int t;
        int a;
        int acc;
        int idx;
    } wr_rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_tile_controller_if #(
        .MAX_ROWS(MR), .MAX_TILES(MT), .ADDR_WIDTH(10)
    ) bus ();

    systolic_tile_controller #(
        .N_SIZE(N), .MAX_ROWS(MR), .MAX_TILES(MT), .ADDR_WIDTH(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    int      wt_b[MT];
    int      rd_n[MT];
    int      sen_n[MT];
    int      rd_q[$];
    wr_rec_t wr_q[$];
    int      done_cnt;
    int      stall_seen;
    int      cur_rows;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic clear_logs();
        for (int t = 0; t < MT; t++) begin
            wt_b[t]  = 0;
            rd_n[t]  = 0;
            sen_n[t] = 0;
        end
        rd_q.delete();
        wr_q.delete();
        done_cnt   = 0;
        stall_seen = 0;
    endtask

    // Observe the array/buffer strobes once per cycle, away from the edge
    always @(negedge clk) begin
        if (!rst) begin
            int t;
            wr_rec_t r;
            t = int'(bus.tile_idx);
            if (!bus.in_valid && bus.busy &&
                wt_b[t] == N && rd_n[t] < cur_rows)
                stall_seen++;
            if (bus.sys_wt_en) wt_b[t]++;
            if (bus.rd_en) begin
                rd_q.push_back(t * 4096 + int'(bus.rd_addr));
                rd_n[t]++;
            end
            if (bus.we) begin
                r.t   = t;
                r.a   = int'(bus.wr_addr);
                r.acc = int'(bus.acc_en);
                r.idx = sen_n[t];
                wr_q.push_back(r);
            end
            if (bus.sys_en) sen_n[t]++;
            if (bus.done) done_cnt++;
        end
    end

    task automatic check_reset_vals();
        chk("rst_ready",     int'(bus.ready),     1);
        chk("rst_busy",      int'(bus.busy),      0);
        chk("rst_done",      int'(bus.done),      0);
        chk("rst_we",        int'(bus.we),        0);
        chk("rst_rd_en",     int'(bus.rd_en),     0);
        chk("rst_sys_en",    int'(bus.sys_en),    0);
        chk("rst_sys_wt_en", int'(bus.sys_wt_en), 0);
        chk("rst_acc_en",    int'(bus.acc_en),    0);
        chk("rst_rd_addr",   int'(bus.rd_addr),   0);
        chk("rst_wr_addr",   int'(bus.wr_addr),   0);
        chk("rst_tile_idx",  int'(bus.tile_idx),  0);
    endtask

    task automatic verify(input int er, input int at);
        int n;
        wr_rec_t r;
        n = at * er;
        for (int t = 0; t < MT; t++) begin
            chk("wt_beats", wt_b[t], (t < at) ? N : 0);
            chk("sys_en_cycles", sen_n[t], (t < at) ? er + LAT : 0);
        end
        chk("rd_count", rd_q.size(), n);
        for (int i = 0; i < n && i < rd_q.size(); i++)
            chk("rd_addr", rd_q[i], (i / er) * 4096 + i % er);
        chk("wr_count", wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            r = wr_q[i];
            chk("wr_tile", r.t, i / er);
            chk("wr_addr", r.a, i % er);
            chk("acc_en", r.acc, ((i / er) != 0) ? 1 : 0);
            chk("we_advance", r.idx, LAT + i % er);
        end
        chk("done_pulses", done_cnt, 1);
        chk("tile_idx_end", int'(bus.tile_idx), (at > 0) ? at - 1 : 0);
`ifdef SYSCTRL_STALL_CNT_EN
        chk("stall_cnt", int'(bus.stall_cnt), stall_seen);
`endif
    endtask

    task automatic run_job(input int rows, input int tiles,
                           input int stall_pct);
        int er, et, at, cyc;
        er = (rows > MR) ? MR : rows;
        et = (tiles > MT) ? MT : tiles;
        at = (er == 0 || et == 0) ? 0 : et;
        clear_logs();
        cur_rows = er;
        @(posedge clk); #1;
        chk("ready_idle", int'(bus.ready), 1);
        bus.start     = 1'b1;
        bus.cfg_rows  = 10'(rows);
        bus.cfg_tiles = 5'(tiles);
        @(posedge clk); #1;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("ready_after_start", int'(bus.ready), 0);
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            // start pulses while busy carry junk config and must be ignored
            bus.start     = ($urandom_range(7) == 0);
            bus.cfg_rows  = 10'($urandom_range(30));
            bus.cfg_tiles = 5'($urandom_range(3));
            bus.wt_valid  = $urandom_range(1);
            bus.in_valid  = ($urandom_range(99) >= stall_pct);
            @(posedge clk); #1;
            cyc++;
        end
        if (done_cnt == 0) chk("job_timeout", 0, 1);
        bus.start = 1'b0;
        repeat (5) begin
            bus.wt_valid = $urandom_range(1);
            bus.in_valid = $urandom_range(1);
            @(posedge clk); #1;
        end
        chk("busy_after_job", int'(bus.busy), 0);
        verify(er, at);
        bus.wt_valid = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic reset_mid_compute();
        int cyc;
        clear_logs();
        cur_rows = 20;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.cfg_rows  = 10'd20;
        bus.cfg_tiles = 5'd2;
        bus.wt_valid  = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (rd_q.size() < 3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_compute", (rd_q.size() >= 3) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals();
        @(posedge clk); #1;
        check_reset_vals();
        bus.start    = 1'b0;
        bus.wt_valid = 1'b0;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_vals();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got 0 want 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.cfg_rows  = 10'd8;
        bus.cfg_tiles = 5'd1;
        bus.wt_valid  = 1'b1;
        bus.in_valid  = 1'b1;
        cur_rows      = 0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        bus.start    = 1'b0;
        bus.wt_valid = 1'b0;
        bus.in_valid = 1'b0;
        rst = 1'b0;

        run_job(8, 1, 0);
        run_job(8, 1, 30);
        run_job(4, 3, 20);
        run_job(0, 2, 0);
        run_job(5, 0, 0);
        run_job(600, 1, 10);
        run_job(1, 2, 50);
        reset_mid_compute();
        run_job(5, 2, 25);
        for (int j = 0; j < 4; j++)
            run_job($urandom_range(1, 20), $urandom_range(1, 4),
                    $urandom_range(40));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
